// File: rtl/vending_pkg.sv
// Shared definitions for the vending controller: coin values, FSM states,
// default price table and the change-coin bundle.
package vending_pkg;

  localparam int unsigned COIN_W = 5;

  localparam logic [COIN_W-1:0] NICKEL_VAL  = 5'd5;
  localparam logic [COIN_W-1:0] DIME_VAL    = 5'd10;
  localparam logic [COIN_W-1:0] QUARTER_VAL = 5'd25;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_VEND   = 2'd1,
    ST_CHANGE = 2'd2
  } state_t;

  // Product 0 in the LSBs: prices 100, 120, 115, 75 cents.
  localparam int unsigned DEF_NUM_PROD = 4;
  localparam int unsigned DEF_PRICE_W  = 8;
  localparam logic [DEF_NUM_PROD*DEF_PRICE_W-1:0] DEFAULT_PRICES =
    {8'd75, 8'd115, 8'd120, 8'd100};

  // One change coin, at most one field set.
  typedef struct packed {
    logic quarter;
    logic dime;
    logic nickel;
  } coin_t;

endpackage

// File: rtl/vend_change_unit.sv
// Greedy change selector: when the dispenser is ready, picks the largest
// coin not exceeding the balance and returns the reduced balance.
//   balance        in   current credit
//   disp_ready     in   dispenser can accept a coin this cycle
//   coin_c         out  selected coin (combinational)
//   balance_next_c out  balance after paying the selected coin (combinational)
module vend_change_unit
  import vending_pkg::*;
#(
  parameter int unsigned BAL_W = 8
) (
  input  logic [BAL_W-1:0] balance,
  input  logic             disp_ready,
  output coin_t            coin_c,
  output logic [BAL_W-1:0] balance_next_c
);

  // Largest-first coin choice; nothing paid while the dispenser stalls.
  always_comb begin
    coin_c         = '0;
    balance_next_c = balance;
    if (disp_ready) begin
      if (balance >= BAL_W'(QUARTER_VAL)) begin
        coin_c.quarter = 1'b1;
        balance_next_c = balance - BAL_W'(QUARTER_VAL);
      end else if (balance >= BAL_W'(DIME_VAL)) begin
        coin_c.dime    = 1'b1;
        balance_next_c = balance - BAL_W'(DIME_VAL);
      end else if (balance >= BAL_W'(NICKEL_VAL)) begin
        coin_c.nickel  = 1'b1;
        balance_next_c = balance - BAL_W'(NICKEL_VAL);
      end
    end
  end

endmodule

// File: rtl/vending_engine.sv
// Vending controller: credits coins, tracks a pending selection, per-product
// price and stock, vends one product and pays change one coin per ready cycle.
//   CLK, RESET            clock, asynchronous active-high reset
//   inquarter/indime/innickle  one-cycle coin pulses
//   insel                 one-hot product select pulse
//   RETURN                refund request (IDLE only)
//   restock, restock_id   refill one product to full
//   disp_ready            change dispenser handshake
//   outquarter/outdime/outnickle  change coin pulses
//   outbev                one-hot vend pulse
//   coin_reject           inserted coin(s) refused
//   sold_out              per-product empty flag (one cycle behind stock)
//   balance               current credit
//   busy                  controller not idle
module vending_engine
  import vending_pkg::*;
#(
  parameter int unsigned NUM_PROD = DEF_NUM_PROD,
  parameter int unsigned PRICE_W  = DEF_PRICE_W,
  parameter logic [NUM_PROD*PRICE_W-1:0] PRICES = DEFAULT_PRICES,
  parameter int unsigned BAL_W    = 8,
  parameter int unsigned BAL_MAX  = 250,
  parameter int unsigned STOCK_W  = 4,
  localparam int unsigned IDX_W   = (NUM_PROD > 1) ? $clog2(NUM_PROD) : 1
) (
  input  logic                CLK,
  input  logic                RESET,
  input  logic                inquarter,
  input  logic                indime,
  input  logic                innickle,
  input  logic [NUM_PROD-1:0] insel,
  input  logic                RETURN,
  input  logic                restock,
  input  logic [IDX_W-1:0]    restock_id,
  input  logic                disp_ready,
  output logic                outquarter,
  output logic                outdime,
  output logic                outnickle,
  output logic [NUM_PROD-1:0] outbev,
  output logic                coin_reject,
  output logic [NUM_PROD-1:0] sold_out,
  output logic [BAL_W-1:0]    balance,
  output logic                busy
);

  localparam int unsigned SUM_W = BAL_W + 1;
  localparam int unsigned CMP_W = ((BAL_W > PRICE_W) ? BAL_W : PRICE_W) + 1;
  localparam logic [STOCK_W-1:0] STOCK_FULL = '1;

  state_t               state, state_nxt;
  logic [BAL_W-1:0]     balance_nxt;
  logic                 pend_vld, pend_vld_nxt;
  logic [IDX_W-1:0]     pend_idx, pend_idx_nxt;
  logic [STOCK_W-1:0]   stock [NUM_PROD];
  logic [NUM_PROD-1:0]  outbev_nxt;
  coin_t                chg_nxt;
  logic                 reject_nxt;

  // Coin decode: count of active lines, value of the single coin, new sum.
  logic [1:0]        coin_cnt_c;
  logic [COIN_W-1:0] coin_val_c;
  logic [SUM_W-1:0]  coin_sum_c;

  always_comb begin
    coin_cnt_c = 2'(inquarter) + 2'(indime) + 2'(innickle);
    coin_val_c = '0;
    if (inquarter)     coin_val_c = QUARTER_VAL;
    else if (indime)   coin_val_c = DIME_VAL;
    else if (innickle) coin_val_c = NICKEL_VAL;
    coin_sum_c = SUM_W'(balance) + SUM_W'(coin_val_c);
  end

  // Selection decode: accepted only if one-hot and the product is in stock.
  logic             sel_hit_c;
  logic [IDX_W-1:0] sel_idx_c;

  always_comb begin
    sel_idx_c = '0;
    for (int i = 0; i < NUM_PROD; i++) begin
      if (insel[i]) sel_idx_c = IDX_W'(i);
    end
    sel_hit_c = $onehot(insel) && (stock[sel_idx_c] != '0);
  end

  // Price of the pending product and the credit left after vending it.
  logic [PRICE_W-1:0] price_c;
  logic               vend_ok_c;
  logic [BAL_W-1:0]   vend_rem_c;

  assign price_c    = PRICES[32'(pend_idx) * PRICE_W +: PRICE_W];
  assign vend_ok_c  = pend_vld && (CMP_W'(balance) >= CMP_W'(price_c));
  assign vend_rem_c = balance - BAL_W'(price_c);

  coin_t            chg_coin_c;
  logic [BAL_W-1:0] chg_bal_c;

  vend_change_unit #(.BAL_W(BAL_W)) u_change (
    .balance        (balance),
    .disp_ready     (disp_ready),
    .coin_c         (chg_coin_c),
    .balance_next_c (chg_bal_c)
  );

  // Next-state and registered-output decode.
  always_comb begin
    state_nxt    = state;
    balance_nxt  = balance;
    pend_vld_nxt = pend_vld;
    pend_idx_nxt = pend_idx;
    outbev_nxt   = '0;
    chg_nxt      = '0;
    reject_nxt   = 1'b0;

    unique case (state)
      ST_IDLE: begin
        if (coin_cnt_c == 2'd1 && coin_sum_c <= SUM_W'(BAL_MAX)) begin
          balance_nxt = coin_sum_c[BAL_W-1:0];
        end else if (coin_cnt_c != 2'd0) begin
          reject_nxt = 1'b1;
        end
        // RETURN beats select/vend; a coin in the same cycle joins the refund.
        if (RETURN) begin
          pend_vld_nxt = 1'b0;
          if (balance_nxt != '0) state_nxt = ST_CHANGE;
        end else if (vend_ok_c) begin
          // Selection is committed here; a new insel this cycle is dropped.
          state_nxt            = ST_VEND;
          outbev_nxt[pend_idx] = 1'b1;
        end else if (sel_hit_c) begin
          pend_vld_nxt = 1'b1;
          pend_idx_nxt = sel_idx_c;
        end
      end
      ST_VEND: begin
        reject_nxt   = (coin_cnt_c != 2'd0);
        balance_nxt  = vend_rem_c;
        pend_vld_nxt = 1'b0;
        state_nxt    = (vend_rem_c != '0) ? ST_CHANGE : ST_IDLE;
      end
      ST_CHANGE: begin
        reject_nxt  = (coin_cnt_c != 2'd0);
        balance_nxt = chg_bal_c;
        chg_nxt     = chg_coin_c;
        if (chg_bal_c == '0) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // State, credit, selection and output pulses.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state       <= ST_IDLE;
      balance     <= '0;
      pend_vld    <= 1'b0;
      pend_idx    <= '0;
      outbev      <= '0;
      outquarter  <= 1'b0;
      outdime     <= 1'b0;
      outnickle   <= 1'b0;
      coin_reject <= 1'b0;
      busy        <= 1'b0;
    end else begin
      state       <= state_nxt;
      balance     <= balance_nxt;
      pend_vld    <= pend_vld_nxt;
      pend_idx    <= pend_idx_nxt;
      outbev      <= outbev_nxt;
      outquarter  <= chg_nxt.quarter;
      outdime     <= chg_nxt.dime;
      outnickle   <= chg_nxt.nickel;
      coin_reject <= reject_nxt;
      busy        <= (state_nxt != ST_IDLE);
    end
  end

  // Stock counters; restock overrides a same-cycle vend decrement.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      for (int i = 0; i < NUM_PROD; i++) stock[i] <= STOCK_FULL;
      sold_out <= '0;
    end else begin
      for (int i = 0; i < NUM_PROD; i++) begin
        if (restock && restock_id == IDX_W'(i)) begin
          stock[i] <= STOCK_FULL;
        end else if (state == ST_VEND && pend_idx == IDX_W'(i)) begin
          stock[i] <= stock[i] - STOCK_W'(1);
        end
        sold_out[i] <= (stock[i] == '0);
      end
    end
  end

endmodule
